// File: rtl/wb_stream_pkg.sv
// Shared types and constants for the byte-stream to Wishbone initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_stream_pkg;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    LEN     = 3'd2,
    WR_DATA = 3'd3,
    WR_CYC  = 3'd4,
    RD_CYC  = 3'd5,
    RD_OUT  = 3'd6,
    DRAIN   = 3'd7
  } state_t;

  // Bit of the first header byte that selects a read packet.
  localparam int RD_FLAG = 7;

  // Only byte lane 0 exists on the 8-bit display-memory slaves.
  localparam logic [3:0] SEL_BYTE0 = 4'b0001;

  // A LEN byte of zero stands for 256 transfers, hence the 9-bit count.
  function automatic logic [8:0] len_to_cnt(input logic [7:0] len);
    return {len == 8'd0, len};
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Counts clocks of an open bus cycle that have gone without an acknowledge.
// Latency: tc is combinational from the count; the count updates one clock after en.
// Backpressure: none; clr has priority over en.
module wb_ack_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  // Cleared whenever no cycle is open, so every cycle starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // Flags the LIMIT-th waiting clock of the current cycle.
  assign tc = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/wb_stream_master.sv
// Byte-stream command packets in, single Wishbone classic read/write cycles out, read bytes returned.
// Latency: cyc rises one clock after the data/LEN byte or the m_ready handshake; ends one clock after ack.
// Backpressure: s_ready low while a bus cycle or read-back is pending; m_valid held until m_ready.
module wb_stream_master
  import wb_stream_pkg::*;
#(
  parameter int AW          = 13,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] wb_adr_o,
  output logic [7:0]    wb_dat_o,
  input  logic [7:0]    wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  input  logic          wb_ack_i,
  output logic          busy,
  output logic          err
);

  localparam int            HI_W    = AW - 8;
  localparam logic [AW-1:0] ADR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state, state_n;
  logic          rd_pkt;
  logic [AW-1:0] adr;
  logic [8:0]    cnt;
  logic [7:0]    wdat;
  logic [7:0]    rdat;
  logic          err_q;

  logic s_rdy;
  logic ld_hi, ld_lo, ld_len, ld_wdat, adv, cnt_dec, cap, err_set;
  logic last;
  logic cyc;
  logic tmo;

  assign last = (cnt == 9'd1);
  assign cyc  = (state == WR_CYC) || (state == RD_CYC);

  wb_ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (!cyc),
    .en    (cyc && !wb_ack_i),
    .tc    (tmo)
  );

  // State register; async reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HDR_HI;
    end else begin
      state <= state_n;
    end
  end

  // Next state and datapath strobes; an ack on the terminal-count clock beats the timeout.
  always_comb begin
    state_n = state;
    s_rdy   = 1'b0;
    ld_hi   = 1'b0;
    ld_lo   = 1'b0;
    ld_len  = 1'b0;
    ld_wdat = 1'b0;
    adv     = 1'b0;
    cnt_dec = 1'b0;
    cap     = 1'b0;
    err_set = 1'b0;
    case (state)
      HDR_HI: begin
        s_rdy = 1'b1;
        if (s_valid) begin
          ld_hi   = 1'b1;
          state_n = HDR_LO;
        end
      end
      HDR_LO: begin
        s_rdy = 1'b1;
        if (s_valid) begin
          ld_lo   = 1'b1;
          state_n = LEN;
        end
      end
      LEN: begin
        s_rdy = 1'b1;
        if (s_valid) begin
          ld_len  = 1'b1;
          state_n = rd_pkt ? RD_CYC : WR_DATA;
        end
      end
      WR_DATA: begin
        s_rdy = 1'b1;
        if (s_valid) begin
          ld_wdat = 1'b1;
          state_n = WR_CYC;
        end
      end
      WR_CYC: begin
        if (wb_ack_i) begin
          adv     = 1'b1;
          state_n = last ? HDR_HI : WR_DATA;
        end else if (tmo) begin
          err_set = 1'b1;
          cnt_dec = 1'b1;
          state_n = last ? HDR_HI : DRAIN;
        end
      end
      RD_CYC: begin
        if (wb_ack_i) begin
          cap     = 1'b1;
          state_n = RD_OUT;
        end else if (tmo) begin
          err_set = 1'b1;
          state_n = HDR_HI;
        end
      end
      RD_OUT: begin
        if (m_ready) begin
          adv     = 1'b1;
          state_n = last ? HDR_HI : RD_CYC;
        end
      end
      DRAIN: begin
        s_rdy = 1'b1;
        if (s_valid) begin
          cnt_dec = 1'b1;
          if (last) begin
            state_n = HDR_HI;
          end
        end
      end
      default: state_n = HDR_HI;
    endcase
  end

  // Header fields, auto-incrementing address, transfer count and data holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pkt <= 1'b0;
      adr    <= '0;
      cnt    <= 9'd0;
      wdat   <= 8'd0;
      rdat   <= 8'd0;
    end else begin
      if (ld_hi) begin
        rd_pkt       <= s_data[RD_FLAG];
        adr[AW-1:8]  <= s_data[HI_W-1:0];
      end
      if (ld_lo) begin
        adr[7:0] <= s_data;
      end
      if (ld_len) begin
        cnt <= len_to_cnt(s_data);
      end
      if (ld_wdat) begin
        wdat <= s_data;
      end
      if (cap) begin
        rdat <= wb_dat_i;
      end
      if (adv) begin
        adr <= adr + ADR_ONE;
      end
      if (adv || cnt_dec) begin
        cnt <= cnt - 9'd1;
      end
    end
  end

  // One-clock error pulse, coincident with the clock the aborted cycle is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_set;
    end
  end

  // Bus and stream outputs decode straight from state so reset clears them without a clock.
  assign s_ready  = s_rdy && reset;
  assign m_valid  = (state == RD_OUT);
  assign m_data   = rdat;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = (state == WR_CYC);
  assign wb_sel_o = cyc ? SEL_BYTE0 : 4'b0000;
  assign wb_adr_o = adr;
  assign wb_dat_o = wdat;
  assign busy     = (state != HDR_HI);
  assign err      = err_q;

endmodule

// File: tb/tb_wb_stream_master.sv
// Directed bench for wb_stream_master with a scripted Wishbone slave and a bus-rule monitor.
// Latency: n/a.
// Backpressure: slave ack delay and m_ready hold are set per test.
module tb_wb_stream_master;

  localparam int AW  = 13;
  localparam int TMO = 255;

  logic          clk;
  logic          reset;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] wb_adr_o;
  logic [7:0]    wb_dat_o;
  logic [7:0]    wb_dat_i;
  logic [3:0]    wb_sel_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic          wb_ack_i;
  logic          busy;
  logic          err;

  wb_stream_master #(.AW(AW), .ACK_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_ack_i (wb_ack_i),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: acks ack_dly clocks into a cycle unless no_ack; logs every acked cycle.
  int            ack_dly = 1;
  logic          no_ack  = 1'b0;
  logic [7:0]    rd_q[$];
  logic [AW-1:0] log_adr[$];
  logic [7:0]    log_dat[$];
  logic          log_we[$];

  initial begin
    int wcnt;
    wcnt     = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!wb_cyc_o || wb_ack_i) begin
        wb_ack_i = 1'b0;
        wcnt     = 0;
      end else if (!no_ack) begin
        if (wcnt >= ack_dly) begin
          wb_ack_i = 1'b1;
          if (!wb_we_o) wb_dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
          log_adr.push_back(wb_adr_o);
          log_dat.push_back(wb_we_o ? wb_dat_o : wb_dat_i);
          log_we.push_back(wb_we_o);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Bus-rule monitor: stb tracks cyc, sel only during cycles, idle clock after every ack.
  int   bad_stb = 0;
  int   bad_sel = 0;
  int   b2b     = 0;
  int   err_cnt = 0;
  logic prev_ack = 1'b0;

  always @(negedge clk) begin
    if (wb_stb_o !== wb_cyc_o) bad_stb <= bad_stb + 1;
    if (wb_sel_o !== (wb_cyc_o ? 4'b0001 : 4'b0000)) bad_sel <= bad_sel + 1;
    if (prev_ack && wb_cyc_o) b2b <= b2b + 1;
    prev_ack <= wb_cyc_o && wb_ack_i;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    n       = 0;
    s_data  = b;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 2000);
    s_valid = 1'b0;
    if (!rdy) chk("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic send_hdr(input logic [7:0] h, input logic [7:0] l, input logic [7:0] len);
    send_byte(h);
    send_byte(l);
    send_byte(len);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         n;
    int         bad;
    int         e0;
    logic [7:0] got[$];

    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_cyc",   32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    chk("rst_sel",   32'(wb_sel_o), 32'd0);
    chk("rst_adr",   32'(wb_adr_o), 32'd0);
    chk("rst_mval",  32'({m_valid, m_data}), 32'd0);
    chk("rst_flags", 32'({busy, err, s_ready}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sready", 32'(s_ready), 32'd1);

    // 1: single write, adr 0x004 dat 0x33
    send_byte(8'h00);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h33);
    chk("t1_cyc_we",  32'({wb_cyc_o, wb_we_o, s_ready}), 32'b110);
    chk("t1_adr_bus", 32'(wb_adr_o), 32'h004);
    wait_idle("t1_idle");
    chk("t1_n",   32'(log_adr.size()), 32'd1);
    chk("t1_adr", 32'(log_adr[0]), 32'h004);
    chk("t1_dat", 32'(log_dat[0]), 32'h33);
    chk("t1_we",  32'(log_we[0]), 32'd1);

    // 2: address wrap 1FFE,1FFF,0000
    base = log_adr.size();
    send_hdr(8'h1F, 8'hFE, 8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_idle("t2_idle");
    chk("t2_n",    32'(log_adr.size() - base), 32'd3);
    chk("t2_adr0", 32'({log_adr[base],   log_dat[base]}),   32'h1FFEAA);
    chk("t2_adr1", 32'({log_adr[base+1], log_dat[base+1]}), 32'h1FFFBB);
    chk("t2_adr2", 32'({log_adr[base+2], log_dat[base+2]}), 32'h0000CC);

    // 3: read two bytes with m_ready held off
    base = log_adr.size();
    rd_q.push_back(8'h5A);
    rd_q.push_back(8'hA5);
    send_hdr(8'h80, 8'h10, 8'h02);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_mvalid", 32'(m_valid), 32'd1);
    chk("t3_mdata",  32'(m_data), 32'h5A);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_data !== 8'h5A || m_valid !== 1'b1 || wb_cyc_o !== 1'b0) bad++;
    end
    chk("t3_hold", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    n = 0;
    while (got.size() < 2 && n < 200) begin
      @(negedge clk);
      if (m_valid) got.push_back(m_data);
      n++;
    end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("t3_cnt", 32'(got.size()), 32'd2);
    if (got.size() == 2) chk("t3_bytes", 32'({got[0], got[1]}), 32'h5AA5);
    wait_idle("t3_idle");
    chk("t3_ncyc", 32'(log_adr.size() - base), 32'd2);
    chk("t3_cyc0", 32'({log_we[base],   log_adr[base]}),   32'h0010);
    chk("t3_cyc1", 32'({log_we[base+1], log_adr[base+1]}), 32'h0011);

    // 4: ack timeout on first of three writes, rest drained
    base    = log_adr.size();
    e0      = err_cnt;
    no_ack  = 1'b1;
    send_hdr(8'h00, 8'h20, 8'h03);
    send_byte(8'h11);
    n = 0;
    @(negedge clk);
    while (wb_cyc_o && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("t4_cyc_len", 32'(n), 32'(TMO));
    chk("t4_err_at_drop", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    no_ack = 1'b0;
    chk("t4_drain_busy", 32'(busy), 32'd1);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("t4_idle_after_drain", 32'(busy), 32'd0);
    chk("t4_no_cycles", 32'(log_adr.size() - base), 32'd0);
    chk("t4_err_once", 32'(err_cnt - e0), 32'd1);
    send_hdr(8'h00, 8'h30, 8'h01);
    send_byte(8'h44);
    wait_idle("t4_next_idle");
    chk("t4_next", 32'({log_adr[base], log_dat[base]}), 32'h003044);

    // 5: LEN 00 means 256 writes at 0x100..0x1FF
    base = log_adr.size();
    send_hdr(8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    wait_idle("t5_idle");
    chk("t5_n", 32'(log_adr.size() - base), 32'd256);
    bad = 0;
    for (int i = 0; i < 256 && base + i < log_adr.size(); i++) begin
      if (log_adr[base+i] !== 13'(32'h100 + i) || log_dat[base+i] !== 8'(i)) bad++;
    end
    chk("t5_seq", 32'(bad), 32'd0);

    // 7: ack on the terminal-count clock wins over the timeout
    base    = log_adr.size();
    e0      = err_cnt;
    ack_dly = TMO - 1;
    send_hdr(8'h00, 8'h60, 8'h01);
    send_byte(8'h77);
    wait_idle("t7_idle");
    ack_dly = 1;
    chk("t7_n",   32'(log_adr.size() - base), 32'd1);
    chk("t7_wr",  32'({log_adr[base], log_dat[base]}), 32'h006077);
    chk("t7_err", 32'(err_cnt - e0), 32'd0);

    // 6: async reset in the middle of a write cycle
    no_ack = 1'b1;
    send_hdr(8'h00, 8'h40, 8'h02);
    send_byte(8'h55);
    chk("t6_cyc_open", 32'(wb_cyc_o), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_bus_drop", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    chk("t6_in_reset", 32'({s_ready, busy, m_valid}), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    no_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_hdr_hi", 32'({busy, s_ready}), 32'b01);
    base = log_adr.size();
    send_hdr(8'h00, 8'h50, 8'h01);
    send_byte(8'h66);
    wait_idle("t6_idle");
    chk("t6_after", 32'({log_adr[base], log_dat[base]}), 32'h005066);

    // Bus rules held throughout
    chk("mon_stb", 32'(bad_stb), 32'd0);
    chk("mon_sel", 32'(bad_sel), 32'd0);
    chk("mon_b2b", 32'(b2b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
